// File: rtl/padctrl_reg_pkg.sv
// Shared constants, FSM state type and index helper for the pad attribute
// update sequencer.
//   NMioPads / NDioPads : pad counts; flat pad index = MIO 0..15, then DIO 0..3
//   AttrDw              : width of one pad attribute slot
//   seq_state_e         : update sequencer FSM states
package padctrl_reg_pkg;

   parameter int unsigned NMioPads = 16;
   parameter int unsigned NDioPads = 4;
   parameter int unsigned AttrDw   = 8;
   parameter int unsigned NPads    = NMioPads + NDioPads;
   parameter int unsigned PadIdxW  = 5;
   parameter int unsigned CntW     = 8;

   typedef enum logic [2:0] {
      StIdle,
      StBlank,
      StWrite,
      StHold,
      StDone
   } seq_state_e;

   // True when a flat pad index addresses an existing MIO or DIO pad.
   function automatic logic pad_idx_legal(input logic [PadIdxW-1:0] idx);
      return int'(idx) < int'(NPads);
   endfunction

endpackage

// File: rtl/padctrl_settle_cnt.sv
// Settle down-counter used to time the output-enable blanking windows.
//   clk_i, rst_ni : clock, asynchronous active-low reset (count clears to 0)
//   load_i        : load load_val_i (takes priority over decrement)
//   load_val_i    : value to load
//   dec_i         : decrement by one; saturates at zero
//   zero_o        : count is zero
module padctrl_settle_cnt
   import padctrl_reg_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            dec_i,
   output logic            zero_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/padctrl_attr_seq.sv
// Pad attribute update sequencer. A granted request blanks the target pad's
// output enable for SettleCycles, writes its attribute for one cycle, keeps
// it blanked for another SettleCycles, then pulses done_o.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_i / gnt_o          : request handshake (gnt_o high only in IDLE)
//   pad_idx_i, attr_i      : target pad (0..15 MIO, 16..19 DIO) and new attribute
//   done_o, err_o, busy_o  : completion pulse, illegal-index pulse, sequencer busy
//   mio_oe_i/o, dio_oe_i/o : core output enables in, gated enables out
//   mio_attr_o, dio_attr_o : registered attributes, slot n at [8n+7:8n]
module padctrl_attr_seq
   import padctrl_reg_pkg::*;
#(
   parameter int unsigned SettleCycles = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_i,
   input  logic [PadIdxW-1:0]           pad_idx_i,
   input  logic [AttrDw-1:0]            attr_i,
   output logic                         gnt_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic                         busy_o,
   input  logic [NMioPads-1:0]          mio_oe_i,
   input  logic [NDioPads-1:0]          dio_oe_i,
   output logic [NMioPads-1:0]          mio_oe_o,
   output logic [NDioPads-1:0]          dio_oe_o,
   output logic [NMioPads*AttrDw-1:0]   mio_attr_o,
   output logic [NDioPads*AttrDw-1:0]   dio_attr_o
);

   // Counter is loaded with SettleCycles-1 so that a state waiting for zero
   // occupies exactly SettleCycles cycles.
   localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

   seq_state_e          state_q, state_d;
   logic [PadIdxW-1:0]  idx_q, idx_d;
   logic [AttrDw-1:0]   attr_lat_q, attr_lat_d;
   logic                err_q, err_d;
   logic [AttrDw-1:0]   attr_mem_q [NPads];

   logic cnt_load, cnt_dec, cnt_zero;
   logic attr_we;
   logic force_en;

   padctrl_settle_cnt u_settle_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load),
      .load_val_i (SettleLoad),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   assign gnt_o = (state_q == StIdle);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      attr_lat_d = attr_lat_q;
      err_d      = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      attr_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (pad_idx_legal(pad_idx_i)) begin
                  idx_d      = pad_idx_i;
                  attr_lat_d = attr_i;
                  cnt_load   = 1'b1;
                  state_d    = StBlank;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StBlank: begin
            if (cnt_zero) begin
               state_d = StWrite;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StWrite: begin
            attr_we  = 1'b1;
            cnt_load = 1'b1;
            state_d  = StHold;
         end
         StHold: begin
            if (cnt_zero) begin
               state_d = StDone;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         attr_lat_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         attr_lat_q <= attr_lat_d;
         err_q      <= err_d;
      end
   end

   // Attribute slots; only the latched target slot is written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NPads); i++) begin
            attr_mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NPads); i++) begin
            if (attr_we && (idx_q == PadIdxW'(i))) begin
               attr_mem_q[i] <= attr_lat_q;
            end
         end
      end
   end

   always_comb begin
      mio_attr_o = '0;
      dio_attr_o = '0;
      for (int i = 0; i < int'(NMioPads); i++) begin
         mio_attr_o[i*AttrDw +: AttrDw] = attr_mem_q[i];
      end
      for (int i = 0; i < int'(NDioPads); i++) begin
         dio_attr_o[i*AttrDw +: AttrDw] = attr_mem_q[NMioPads + i];
      end
   end

   // Target pad is blanked from the first BLANK cycle through the last HOLD cycle.
   assign force_en = (state_q == StBlank) || (state_q == StWrite) || (state_q == StHold);

   always_comb begin
      mio_oe_o = mio_oe_i;
      dio_oe_o = dio_oe_i;
      for (int i = 0; i < int'(NMioPads); i++) begin
         if (force_en && (idx_q == PadIdxW'(i))) begin
            mio_oe_o[i] = 1'b0;
         end
      end
      for (int i = 0; i < int'(NDioPads); i++) begin
         if (force_en && (idx_q == PadIdxW'(NMioPads + i))) begin
            dio_oe_o[i] = 1'b0;
         end
      end
   end

   assign done_o = (state_q == StDone);
   assign err_o  = err_q;
   assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_padctrl_attr_seq.sv
module tb_padctrl_attr_seq;

   localparam int S = 4;

   logic         clk_i;
   logic         rst_ni;
   logic         req_i;
   logic [4:0]   pad_idx_i;
   logic [7:0]   attr_i;
   logic         gnt_o, done_o, err_o, busy_o;
   logic [15:0]  mio_oe_i, mio_oe_o;
   logic [3:0]   dio_oe_i, dio_oe_o;
   logic [127:0] mio_attr_o;
   logic [31:0]  dio_attr_o;

   int n_checks = 0;
   int n_pass   = 0;
   bit fixed_oe = 1'b0;

   // Reference model: one attribute byte per flat pad index.
   logic [7:0] model_attr [20];

   padctrl_attr_seq #(.SettleCycles(S)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .pad_idx_i  (pad_idx_i),
      .attr_i     (attr_i),
      .gnt_o      (gnt_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .busy_o     (busy_o),
      .mio_oe_i   (mio_oe_i),
      .dio_oe_i   (dio_oe_i),
      .mio_oe_o   (mio_oe_o),
      .dio_oe_o   (dio_oe_o),
      .mio_attr_o (mio_attr_o),
      .dio_attr_o (dio_attr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] exp_mio_attr();
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = model_attr[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_dio_attr();
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = model_attr[16+i];
      return v;
   endfunction

   task automatic drive_oe();
      if (fixed_oe) begin
         mio_oe_i = 16'hFFFF;
         dio_oe_i = 4'hF;
      end else begin
         mio_oe_i = 16'($urandom);
         dio_oe_i = 4'($urandom);
      end
   endtask

   // Compare every output for cycle k after acceptance of (idx, a).
   task automatic check_cycle(input int idx, input int k);
      bit          legal  = (idx < 20);
      bit          active = legal && (k >= 1) && (k <= 2*S+1);
      logic [15:0] mio_e  = mio_oe_i;
      logic [3:0]  dio_e  = dio_oe_i;
      if (active && idx < 16) mio_e[idx] = 1'b0;
      if (active && idx >= 16) dio_e[idx-16] = 1'b0;
      check("busy", 128'(busy_o), 128'(legal && k <= 2*S+2));
      check("gnt", 128'(gnt_o), 128'(!(legal && k <= 2*S+2)));
      check("done", 128'(done_o), 128'(legal && k == 2*S+2));
      check("err", 128'(err_o), 128'(!legal && k == 1));
      check("mio_oe", 128'(mio_oe_o), 128'(mio_e));
      check("dio_oe", 128'(dio_oe_o), 128'(dio_e));
      check("mio_attr", mio_attr_o, exp_mio_attr());
      check("dio_attr", 128'(dio_attr_o), 128'(exp_dio_attr()));
   endtask

   // Follow a request from its acceptance edge. With hold set, req_i stays high
   // carrying (nidx, nattr) so it is taken on the first IDLE cycle. stop > 0
   // ends tracking early at that cycle.
   task automatic track(input int idx, input logic [7:0] a, input bit hold,
                        input int nidx, input logic [7:0] nattr, input int stop);
      int last = (idx < 20) ? 2*S+3 : 2;
      if (stop > 0) last = stop;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk_i);
         drive_oe();
         if (k == 1) begin
            if (hold) begin
               req_i     = 1'b1;
               pad_idx_i = 5'(nidx);
               attr_i    = nattr;
            end else begin
               req_i     = 1'b0;
               pad_idx_i = 5'($urandom);
               attr_i    = 8'($urandom);
            end
         end
         if (idx < 20 && k == S+2) model_attr[idx] = a;
         #1;
         check_cycle(idx, k);
      end
   endtask

   task automatic issue(input int idx, input logic [7:0] a, input bit hold,
                        input int nidx, input logic [7:0] nattr, input int stop);
      int w = 0;
      @(negedge clk_i);
      while (!gnt_o && w < 50) begin
         @(negedge clk_i);
         w++;
      end
      check("gnt_wait", 128'(gnt_o), 128'(1));
      req_i     = 1'b1;
      pad_idx_i = 5'(idx);
      attr_i    = a;
      @(posedge clk_i);
      track(idx, a, hold, nidx, nattr, stop);
   endtask

   initial begin
      for (int i = 0; i < 20; i++) model_attr[i] = 8'h00;
      rst_ni    = 1'b0;
      req_i     = 1'b0;
      pad_idx_i = '0;
      attr_i    = '0;
      mio_oe_i  = 16'hA5C3;
      dio_oe_i  = 4'h9;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_gnt", 128'(gnt_o), 128'(1));
      check("rst_busy", 128'(busy_o), 128'(0));
      check("rst_done", 128'(done_o), 128'(0));
      check("rst_err", 128'(err_o), 128'(0));
      check("rst_mio_attr", mio_attr_o, 128'(0));
      check("rst_dio_attr", 128'(dio_attr_o), 128'(0));
      check("rst_mio_oe", 128'(mio_oe_o), 128'(16'hA5C3));
      check("rst_dio_oe", 128'(dio_oe_o), 128'(4'h9));
      rst_ni = 1'b1;

      // Pad 3 with all enables high: forced window, write point, done, regrant.
      fixed_oe = 1'b1;
      issue(3, 8'h01, 1'b0, 0, 8'h00, 0);
      fixed_oe = 1'b0;

      // DIO pad 2.
      issue(18, 8'hA5, 1'b0, 0, 8'h00, 0);

      // Illegal indices.
      issue(20, 8'h77, 1'b0, 0, 8'h00, 0);
      issue(31, 8'h88, 1'b0, 0, 8'h00, 0);

      // Request held while busy, taken on the first IDLE cycle.
      issue(7, 8'h11, 1'b1, 9, 8'h22, 0);
      @(posedge clk_i);
      track(9, 8'h22, 1'b0, 0, 8'h00, 0);

      // Same value twice still runs the full sequence.
      issue(5, 8'h3C, 1'b0, 0, 8'h00, 0);
      issue(5, 8'h3C, 1'b0, 0, 8'h00, 0);

      // Randomized requests, some illegal, some back-to-back via a held request.
      for (int r = 0; r < 10; r++) begin
         int         idx  = int'($urandom_range(0, 23));
         logic [7:0] a    = 8'($urandom);
         bit         hold = (idx < 20) && ($urandom_range(0, 2) == 0);
         int         nidx = int'($urandom_range(0, 19));
         logic [7:0] na   = 8'($urandom);
         issue(idx, a, hold, nidx, na, 0);
         if (hold) begin
            @(posedge clk_i);
            track(nidx, na, 1'b0, 0, 8'h00, 0);
         end
      end

      // Reset in cycle 7 of a pad 0 update: sequence aborts, state cleared.
      issue(0, 8'h5A, 1'b0, 0, 8'h00, 6);
      @(negedge clk_i);
      drive_oe();
      rst_ni = 1'b0;
      for (int i = 0; i < 20; i++) model_attr[i] = 8'h00;
      #1;
      check("abort_mio_oe", 128'(mio_oe_o), 128'(mio_oe_i));
      check("abort_dio_oe", 128'(dio_oe_o), 128'(dio_oe_i));
      check("abort_mio_attr", mio_attr_o, exp_mio_attr());
      check("abort_done", 128'(done_o), 128'(0));
      check("abort_busy", 128'(busy_o), 128'(0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         #1;
         check("abort_no_done", 128'(done_o), 128'(0));
      end
      rst_ni = 1'b1;

      issue(int'($urandom_range(0, 19)), 8'($urandom), 1'b0, 0, 8'h00, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/padctrl_attr_seq.md
PADCTRL_ATTR_SEQ -- requirements
Module: padctrl_attr_seq

Interface
REQ-001 SHALL have parameter SettleCycles, default 4: number of cycles the target pad's output enable is held low before and after an attribute change; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all logic is in this domain.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_i, input, 1 bit: attribute-update request valid.
REQ-005 SHALL have port pad_idx_i, input, 5 bits: target pad; 0..15 are MIO pads, 16..19 are DIO pads 0..3.
REQ-006 SHALL have port attr_i, input, AttrDw (8) bits: new attribute value; bit 0 is the output-invert bit.
REQ-007 SHALL have port gnt_o, output, 1 bit: request accepted when req_i and gnt_o are both high.
REQ-008 SHALL have port done_o, output, 1 bit: one-cycle pulse when an update completes.
REQ-009 SHALL have port err_o, output, 1 bit: one-cycle pulse when a request with an illegal index is rejected.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port mio_oe_i, input, NMioPads (16) bits: core MIO output enables.
REQ-012 SHALL have port dio_oe_i, input, NDioPads (4) bits: core DIO output enables.
REQ-013 SHALL have port mio_oe_o, output, 16 bits: gated MIO output enables to the padring.
REQ-014 SHALL have port dio_oe_o, output, 4 bits: gated DIO output enables to the padring.
REQ-015 SHALL have port mio_attr_o, output, 16*8 bits: registered MIO attributes; pad n occupies bits [8n+7:8n].
REQ-016 SHALL have port dio_attr_o, output, 4*8 bits: registered DIO attributes, packed the same way.

Function
REQ-017 FSM states SHALL be IDLE, BLANK, WRITE, HOLD and DONE.
REQ-018 gnt_o SHALL equal (state==IDLE); it is combinational from state only and does not depend on req_i.
REQ-019 An accepted request with pad_idx_i >= 20 SHALL pulse err_o in the following cycle, leave state in IDLE and change no attribute.
REQ-020 An accepted legal request SHALL latch pad_idx_i and attr_i, then enter BLANK.
REQ-021 BLANK SHALL last exactly SettleCycles cycles using a down-counter, then go to WRITE.
REQ-022 WRITE SHALL last one cycle; the latched attribute SHALL be written into the target slot at the end of WRITE, so it is visible from the first HOLD cycle.
REQ-023 HOLD SHALL last exactly SettleCycles cycles, then go to DONE.
REQ-024 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-025 During BLANK, WRITE and HOLD, the target pad's oe_o bit SHALL be forced to 0; in all other states and for all other pads, oe_o SHALL equal oe_i combinationally.
REQ-026 Latency from the acceptance edge to done_o SHALL be 2*SettleCycles+2 cycles; gnt_o is high again on the following cycle.
REQ-027 A legal request whose attr_i equals the current attribute SHALL still run the full sequence; there is no short-cut.
REQ-028 Only the target 8-bit slot SHALL change on a write; all other slots hold their values.
REQ-029 req_i, pad_idx_i and attr_i SHALL be ignored while gnt_o is low, and no request is queued.
REQ-030 done_o and err_o SHALL never be high in the same cycle.

Reset
REQ-031 Asserting rst_ni low SHALL, asynchronously:
  - set the state to IDLE and the counter to 0;
  - clear all attributes to 0;
  - drive done_o=0, err_o=0 and busy_o=0.
REQ-032 After reset, gnt_o=1 and oe_o equals oe_i for every pad.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence without a done_o pulse and immediately release the forced oe bit.

Structure
REQ-034 NMioPads, NDioPads and AttrDw SHALL come from padctrl_reg_pkg.
REQ-035 The FSM state typedef SHALL live in padctrl_reg_pkg.
REQ-036 The settle down-counter SHALL be a sub-module, padctrl_settle_cnt, with load, decrement and zero-flag ports.
REQ-037 All attribute storage SHALL be flops; there is no memory macro.

Verification
REQ-038 Reset, then request pad 3 with attr 0x01, SettleCycles=4, mio_oe_i=0xFFFF -> mio_oe_o=0xFFF7 for cycles 1..9; mio_attr_o[31:24]=0x01 from cycle 6; done_o pulses at cycle 10; gnt_o=1 at cycle 11.
REQ-039 Request pad 18 with attr 0xA5 -> dio_attr_o[23:16]=0xA5; dio_oe_o[2] is forced to 0 during the sequence; all MIO outputs are unaffected.
REQ-040 Request pad 20, and separately pad 31 -> err_o pulses once per request; attributes unchanged; busy_o stays 0.
REQ-041 Hold req_i high with a new index while busy -> gnt_o=0 and the request is ignored; the held request is accepted on the first IDLE cycle after done_o.
REQ-042 Assert rst_ni low in cycle 7 of a pad 0 update -> no done_o; mio_attr_o=0; mio_oe_o equals mio_oe_i immediately.
REQ-043 Write pad 5 with 0x3C, then write pad 5 again with 0x3C -> both sequences run the full 2*SettleCycles+2 latency.
